barrett_reduce_pipe: RTL and testbench
======================================

BARRETT_REDUCE_PIPE -- requirements
Module: barrett_reduce_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the maximum modulus bit length.
REQ-002 SHALL have parameter KW, default 6, the width of k_len; KW SHALL be at least clog2(WIDTH+1).
REQ-003 sys_clk  in  1  the single clock; all state SHALL update on its rising edge.
REQ-004 sys_rst  in  1  reset; synchronous and active-high.
REQ-005 in_valid  in  1  the operand set is valid.
REQ-006 in_ready  out  1  the block accepts an operand set this cycle.
REQ-007 x  in  2*WIDTH  the dividend; x < m*m is required.
REQ-008 m  in  WIDTH  the modulus, nonzero.
REQ-009 k_len  in  KW  the bit length of m, 1..WIDTH.
REQ-010 mu  in  WIDTH+1  the Barrett constant, floor(2^(2*k_len)/m).
REQ-011 out_valid  out  1  the result is valid.
REQ-012 out_ready  in  1  the consumer takes the result.
REQ-013 remainder  out  WIDTH  x mod m.
REQ-014 out_err  out  1  the precondition was violated (see REQ-022).

Function
REQ-015 The FSM SHALL have states IDLE, MUL1, MUL2, SUB, CORR and DONE.
REQ-016 A transfer SHALL occur on a rising edge where in_valid && in_ready; x, m, mu and k_len SHALL be captured, q1 = x >> (k_len-1) SHALL be registered, and the state SHALL become MUL1.
REQ-017 Each of the following steps SHALL take exactly one cycle:
- MUL1: q2 = q1*mu, full (2*WIDTH+2)-bit product, then to MUL2.
- MUL2: q3 = q2 >> (k_len+1); p = q3*m, then to SUB.
- SUB: r = x - p, 2*WIDTH+1 bits, exact and non-negative for legal inputs, then to CORR.
- CORR: select r, r-m or r-2m, the smallest non-negative of the three, then to DONE.
REQ-018 The block SHALL contain exactly one WIDTH+1 by WIDTH+1 multiplier, shared by MUL1 and MUL2 through a state-selected mux.
REQ-019 out_valid SHALL be high exactly in DONE; latency from the accept edge to the first out_valid cycle SHALL be 4 cycles.
REQ-020 In DONE without out_ready, remainder, out_err and out_valid SHALL hold stable.
REQ-021 in_ready SHALL be high in IDLE, and in DONE when out_ready is high, giving back-to-back operation.
- If DONE, out_ready and in_valid coincide, the new set SHALL be accepted and the state SHALL go to MUL1.
- If DONE and out_ready are high but in_valid is low, the state SHALL go to IDLE.
REQ-022 out_err SHALL be 1 when r-2m >= m, i.e. r >= 3m; remainder is then don't-care. out_err SHALL be 0 otherwise.
REQ-023 in_ready SHALL be low in MUL1, MUL2, SUB and CORR; in_valid SHALL be ignored there.

Reset
REQ-024 While sys_rst is high, state SHALL be IDLE, and out_valid, out_err and remainder SHALL be 0 on the next edge.
REQ-025 While sys_rst is high, in_ready SHALL be 0.
REQ-026 Reset asserted mid-operation in any state SHALL abort it with no result produced; in_ready SHALL be 1 in the first cycle after release.

Configuration
REQ-027 With macro BARRETT_QUOTIENT_OUT_EN defined, the block SHALL have:
- an output port quotient [WIDTH:0], equal to q3 plus the number of corrections applied in CORR (0, 1 or 2);
- quotient reset to 0 and held with remainder.
REQ-028 Without BARRETT_QUOTIENT_OUT_EN, the quotient port and its register SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-029 WIDTH=32; m=7, k_len=3, mu=9, x=48; in_valid pulsed in IDLE -> out_valid 4 cycles after accept; remainder=6, out_err=0, quotient=6.
REQ-030 m=15, k_len=4, mu=17, x=30 (one correction) -> remainder=0, quotient=2, out_err=0.
REQ-031 m=2147483647, k_len=31, mu=2147483649, x=4294967296 -> remainder=2, quotient=2.
REQ-032 m=7, k_len=3, mu=0, x=48 -> out_err=1.
REQ-033 Hold out_ready low for 5 cycles -> outputs stable in DONE. Then raise out_ready with in_valid high -> new set accepted that edge, next out_valid 4 cycles later.
REQ-034 Assert sys_rst for 1 cycle while in MUL2 -> out_valid never rises for that set; in_ready=1 in the first cycle after release.

Source files
------------

// File: rtl/barrett_reduce_pipe.sv
// Multi-cycle Barrett reduction: remainder = x mod m using one shared (WIDTH+1)x(WIDTH+1) multiplier.
// Optional quotient output enabled by defining BARRETT_QUOTIENT_OUT_EN.
module barrett_reduce_pipe #(
  parameter int WIDTH = 32,
  parameter int KW    = 6
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]     m,
  input  logic [KW-1:0]        k_len,
  input  logic [WIDTH:0]       mu,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     remainder,
  output logic                 out_err
`ifdef BARRETT_QUOTIENT_OUT_EN
  ,
  output logic [WIDTH:0]       quotient
`endif
);

  localparam int PW = 2*WIDTH + 2;
  localparam int RW = 2*WIDTH + 1;

  typedef enum logic [2:0] {IDLE, MUL1, MUL2, SUB, CORR, DONE} state_t;

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   x_q, x_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [WIDTH:0]       mu_q, mu_d;
  logic [KW-1:0]        k_q, k_d;
  logic [WIDTH:0]       q1_q, q1_d;
  logic [PW-1:0]        prod_q, prod_d;
  logic [RW-1:0]        r_q, r_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic                 err_q, err_d;
`ifdef BARRETT_QUOTIENT_OUT_EN
  logic [WIDTH:0]       q3_q, q3_d;
  logic [WIDTH:0]       quo_q, quo_d;
  logic [1:0]           cnt;
`endif

  logic [KW-1:0]        sh1;
  logic [KW:0]          sh2;
  logic [WIDTH:0]       q3;
  logic [WIDTH:0]       mul_a, mul_b;
  logic [PW-1:0]        prod;
  logic [RW-1:0]        m1x, m2x, m3x;
  logic                 accept;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    m_d     = m_q;
    mu_d    = mu_q;
    k_d     = k_q;
    q1_d    = q1_q;
    prod_d  = prod_q;
    r_d     = r_q;
    rem_d   = rem_q;
    err_d   = err_q;
`ifdef BARRETT_QUOTIENT_OUT_EN
    q3_d    = q3_q;
    quo_d   = quo_q;
    cnt     = 2'd0;
`endif

    in_ready = !sys_rst && ((state_q == IDLE) || (state_q == DONE && out_ready));
    accept   = in_valid && in_ready;

    sh1 = k_len - KW'(1);
    sh2 = {1'b0, k_q} + (KW+1)'(1);
    q3  = (WIDTH+1)'(prod_q >> sh2);

    // The one multiplier: q1*mu in MUL1, q3*m in MUL2.
    mul_a = (state_q == MUL1) ? q1_q : q3;
    mul_b = (state_q == MUL1) ? mu_q : {1'b0, m_q};
    prod  = PW'(mul_a) * PW'(mul_b);

    m1x = RW'(m_q);
    m2x = m1x << 1;
    m3x = m1x + m2x;

    case (state_q)
      MUL1: begin
        prod_d  = prod;
        state_d = MUL2;
      end
      MUL2: begin
        prod_d  = prod;
`ifdef BARRETT_QUOTIENT_OUT_EN
        q3_d    = q3;
`endif
        state_d = SUB;
      end
      SUB: begin
        r_d     = RW'({2'b00, x_q} - prod_q);
        state_d = CORR;
      end
      CORR: begin
        err_d = (r_q >= m3x);
        if (r_q < m1x) begin
          rem_d = WIDTH'(r_q);
        end else if (r_q < m2x) begin
          rem_d = WIDTH'(r_q - m1x);
`ifdef BARRETT_QUOTIENT_OUT_EN
          cnt   = 2'd1;
`endif
        end else begin
          rem_d = WIDTH'(r_q - m2x);
`ifdef BARRETT_QUOTIENT_OUT_EN
          cnt   = 2'd2;
`endif
        end
`ifdef BARRETT_QUOTIENT_OUT_EN
        quo_d   = q3_q + (WIDTH+1)'(cnt);
`endif
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Acceptance overrides the IDLE/DONE exit so back-to-back sets go straight to MUL1.
    if (accept) begin
      x_d     = x;
      m_d     = m;
      mu_d    = mu;
      k_d     = k_len;
      q1_d    = (WIDTH+1)'(x >> sh1);
      state_d = MUL1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      err_q   <= 1'b0;
`ifdef BARRETT_QUOTIENT_OUT_EN
      quo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
`ifdef BARRETT_QUOTIENT_OUT_EN
      quo_q   <= quo_d;
`endif
    end
  end

  always_ff @(posedge sys_clk) begin
    x_q    <= x_d;
    m_q    <= m_d;
    mu_q   <= mu_d;
    k_q    <= k_d;
    q1_q   <= q1_d;
    prod_q <= prod_d;
    r_q    <= r_d;
`ifdef BARRETT_QUOTIENT_OUT_EN
    q3_q   <= q3_d;
`endif
  end

  assign out_valid = (state_q == DONE);
  assign remainder = rem_q;
  assign out_err   = err_q;
`ifdef BARRETT_QUOTIENT_OUT_EN
  assign quotient  = quo_q;
`endif

endmodule

// File: tb/tb_barrett_reduce_pipe.sv
// Scoreboard bench for barrett_reduce_pipe: directed vectors, decoupled monitor.
module tb_barrett_reduce_pipe;
  localparam int W = 32;

  logic            sys_clk = 1'b0;
  logic            sys_rst;
  logic            in_valid;
  logic            in_ready;
  logic [2*W-1:0]  x;
  logic [W-1:0]    m;
  logic [5:0]      k_len;
  logic [W:0]      mu;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    remainder;
  logic            out_err;
`ifdef BARRETT_QUOTIENT_OUT_EN
  logic [W:0]      quotient;
`endif

  always #5 sys_clk = ~sys_clk;

  barrett_reduce_pipe #(.WIDTH(W), .KW(6)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .m(m), .k_len(k_len), .mu(mu),
    .out_valid(out_valid), .out_ready(out_ready),
    .remainder(remainder), .out_err(out_err)
`ifdef BARRETT_QUOTIENT_OUT_EN
    , .quotient(quotient)
`endif
  );

  typedef struct {
    logic [W-1:0] rem;
    logic         err;
    logic [W:0]   quo;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   vstart = -1;

  initial forever begin
    @(posedge sys_clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Monitor: pops expected results on each output handshake.
  initial forever begin
    exp_t e;
    @(negedge sys_clk);
    if (sys_rst) begin
      vstart = -1;
    end else begin
      if (out_valid && vstart < 0) vstart = cyc;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", 64'(out_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          chk("latency", 64'(vstart - e.acc), 64'd4);
          chk("out_err", 64'(out_err), 64'(e.err));
          if (!e.err) begin
            chk("remainder", 64'(remainder), 64'(e.rem));
`ifdef BARRETT_QUOTIENT_OUT_EN
            chk("quotient", 64'(quotient), 64'(e.quo));
`endif
          end
        end
        vstart = -1;
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [63:0] xv, input logic [31:0] mv, input int kv,
                      input logic [32:0] muv, input logic [31:0] er, input logic ee,
                      input logic [32:0] eq, input bit push, output int waits);
    exp_t e;
    bit ok = 0;
    x = xv; m = mv; k_len = 6'(kv); mu = muv; in_valid = 1'b1;
    waits = 0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge sys_clk);
      if (in_ready) begin
        ok = 1;
        if (push) begin
          e.rem = er; e.err = ee; e.quo = eq; e.acc = cyc + 1;
          sb.push_back(e);
        end
      end else begin
        waits++;
      end
    end
    if (!ok) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge sys_clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    bit done = 0;
    for (int n = 0; n < 60 && !done; n++) begin
      @(negedge sys_clk);
      if (sb.size() == 0 && !out_valid) done = 1;
    end
    if (!done) chk("drain_timeout", 64'd0, 64'd1);
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    int w;
    logic [W-1:0] hold_rem;
    sys_rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    x = '0; m = '0; k_len = '0; mu = '0;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_remainder", 64'(remainder), 64'd0);
    chk("rst_out_err", 64'(out_err), 64'd0);
`ifdef BARRETT_QUOTIENT_OUT_EN
    chk("rst_quotient", 64'(quotient), 64'd0);
`endif
    @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("idle_in_ready", 64'(in_ready), 64'd1);
    @(posedge sys_clk);
    #1;

    // Back-to-back directed vectors
    send(64'd48, 32'd7, 3, 33'd9, 32'd6, 1'b0, 33'd6, 1, w);
    send(64'd30, 32'd15, 4, 33'd17, 32'd0, 1'b0, 33'd2, 1, w);
    send(64'h1_0000_0000, 32'd2147483647, 31, 33'd2147483649, 32'd2, 1'b0, 33'd2, 1, w);
    send(64'd48, 32'd7, 3, 33'd0, 32'd0, 1'b1, 33'd0, 1, w);
    send(64'd65024, 32'd255, 8, 33'd257, 32'd254, 1'b0, 33'd254, 1, w);
    send(64'hFFFF_FFFE_0000_0000, 32'hFFFF_FFFF, 32, 33'h1_0000_0001,
         32'hFFFF_FFFE, 1'b0, 33'h0_FFFF_FFFE, 1, w);
    send(64'd0, 32'd1, 1, 33'd4, 32'd0, 1'b0, 33'd0, 1, w);
    drain();

    // Backpressure: hold in DONE, then release with a new set waiting
    out_ready = 1'b0;
    send(64'd48, 32'd7, 3, 33'd9, 32'd6, 1'b0, 33'd6, 1, w);
    for (int n = 0; n < 20 && !out_valid; n++) @(negedge sys_clk);
    hold_rem = remainder;
    chk("stall_rem_first", 64'(hold_rem), 64'd6);
    for (int n = 0; n < 5; n++) begin
      @(negedge sys_clk);
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_rem", 64'(remainder), 64'(hold_rem));
      chk("stall_err", 64'(out_err), 64'd0);
    end
    @(posedge sys_clk);
    #1 out_ready = 1'b1;
    send(64'd30, 32'd15, 4, 33'd17, 32'd0, 1'b0, 33'd2, 1, w);
    chk("release_accept_waits", 64'(w), 64'd0);
    drain();

    // Reset during MUL2 aborts the set
    send(64'd48, 32'd7, 3, 33'd9, 32'd6, 1'b0, 33'd6, 0, w);
    @(posedge sys_clk);
    #1 sys_rst = 1'b1;
    @(negedge sys_clk);
    chk("abort_rst_in_ready", 64'(in_ready), 64'd0);
    @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("abort_release_in_ready", 64'(in_ready), 64'd1);
    for (int n = 0; n < 8; n++) begin
      chk("abort_no_valid", 64'(out_valid), 64'd0);
      @(negedge sys_clk);
    end
    @(posedge sys_clk);
    #1;
    send(64'd30, 32'd15, 4, 33'd17, 32'd0, 1'b0, 33'd2, 1, w);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
